sign_extend: RTL and testbench



---
 rtl/core_pkg.sv | 28 ++
 rtl/imm_decode.sv | 58 +++++
 rtl/sign_extend.sv | 54 +++++
 tb/tb_sign_extend.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: RV opcodes, immediate format encoding and the
// default datapath width used by the ID-stage immediate generator.
package core_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LOADFP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_STOREFP = 7'b0100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder.
//   i_instr : raw 32-bit instruction word
//   o_fmt   : decoded immediate format (IMM_NONE for opcodes without one)
//   o_imm   : assembled immediate, sign-extended from bit 31 of the word
import core_pkg::*;

module imm_decode #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic [ILEN-1:0] i_instr,
  output imm_fmt_e        o_fmt,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;
  logic        w_s;

  assign w_s = i_instr[31];

  always_comb begin
    o_fmt   = IMM_NONE;
    w_imm32 = 32'h0;
    case (i_instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_LOADFP: begin
        // shifts stay plain I; shamt masking happens in the ALU decoder
        o_fmt   = IMM_I;
        w_imm32 = {{20{w_s}}, i_instr[31:20]};
      end
      OPC_STORE, OPC_STOREFP: begin
        o_fmt   = IMM_S;
        w_imm32 = {{20{w_s}}, i_instr[31:25], i_instr[11:7]};
      end
      OPC_BRANCH: begin
        o_fmt   = IMM_B;
        w_imm32 = {{19{w_s}}, i_instr[31], i_instr[7], i_instr[30:25],
                   i_instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        o_fmt   = IMM_U;
        w_imm32 = {i_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        o_fmt   = IMM_J;
        w_imm32 = {{11{w_s}}, i_instr[31], i_instr[19:12], i_instr[20],
                   i_instr[30:21], 1'b0};
      end
      default: begin
        o_fmt   = IMM_NONE;
        w_imm32 = 32'h0;
      end
    endcase
  end

  // Every format, U included, extends bit 31 up to XLEN (RV64 LUI semantics).
  assign o_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};

endmodule

// File: rtl/sign_extend.sv
// Registered RV64 immediate generator (ID stage).
//   clk, rst_n : clock, async active-low reset
//   in_valid   : IN carries an instruction this cycle
//   IN         : raw instruction word
//   out_valid  : registered in_valid
//   OUT        : sign-extended immediate, held while in_valid=0
//   imm_fmt    : decoded format (0=NONE,1=I,2=S,3=B,4=U,5=J)
import core_pkg::*;

module sign_extend #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [ILEN-1:0] IN,
  output logic            out_valid,
  output logic [XLEN-1:0] OUT,
  output logic [2:0]      imm_fmt
);

  imm_fmt_e        w_fmt;
  logic [XLEN-1:0] w_imm;

  imm_fmt_e        r_fmt;
  logic [XLEN-1:0] r_out;
  logic            r_vld;

  imm_decode #(.XLEN(XLEN), .ILEN(ILEN)) u_dec (
    .i_instr (IN),
    .o_fmt   (w_fmt),
    .o_imm   (w_imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_fmt <= IMM_NONE;
      r_vld <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_out <= w_imm;
        r_fmt <= w_fmt;
      end
    end
  end

  assign out_valid = r_vld;
  assign OUT       = r_out;
  assign imm_fmt   = r_fmt;

endmodule

// File: tb/tb_sign_extend.sv
module tb_sign_extend;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] IN = 32'h0;
  logic        out_valid;
  logic [63:0] OUT;
  logic [2:0]  imm_fmt;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_out = 64'h0;
  logic [2:0]  exp_fmt = 3'd0;
  logic        exp_vld = 1'b0;

  always #5 clk = ~clk;

  sign_extend #(.XLEN(64), .ILEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .IN(IN),
    .out_valid(out_valid), .OUT(OUT), .imm_fmt(imm_fmt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: immediate value computed as a signed number from its fields.
  function automatic void ref_model(input logic [31:0] w, output logic [2:0] fmt,
                                    output logic [63:0] val);
    longint v;
    longint s;
    s = w[31] ? 1 : 0;
    v = 0;
    fmt = 3'd0;
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b0000111: begin
        fmt = 3'd1;
        v = -s * 2048 + longint'(w[30:20]);
      end
      7'b0100011, 7'b0100111: begin
        fmt = 3'd2;
        v = -s * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:7]);
      end
      7'b1100011: begin
        fmt = 3'd3;
        v = -s * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
            + longint'(w[11:8]) * 2;
      end
      7'b0110111, 7'b0010111: begin
        fmt = 3'd4;
        v = -s * 64'sd2147483648 + longint'(w[30:12]) * 4096;
      end
      7'b1101111: begin
        fmt = 3'd5;
        v = -s * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
            + longint'(w[30:21]) * 2;
      end
      default: begin
        fmt = 3'd0;
        v = 0;
      end
    endcase
    val = 64'(v);
  endfunction

  // Drive one cycle, then compare all outputs against the model.
  task automatic step(input logic v, input logic [31:0] w, input string tag);
    logic [2:0]  f;
    logic [63:0] x;
    in_valid = v;
    IN = w;
    @(posedge clk);
    #1;
    exp_vld = v;
    if (v) begin
      ref_model(w, f, x);
      exp_out = x;
      exp_fmt = f;
    end
    chk({tag, ".vld"}, {63'b0, out_valid}, {63'b0, exp_vld});
    chk({tag, ".out"}, OUT, exp_out);
    chk({tag, ".fmt"}, {61'b0, imm_fmt}, {61'b0, exp_fmt});
  endtask

  logic [6:0] opc_tbl [0:11] = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111,
                                 7'b0000111, 7'b0100011, 7'b0100111, 7'b1100011,
                                 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};

  initial begin
    logic [31:0] w;
    #2;
    chk("rst.vld", {63'b0, out_valid}, 64'h0);
    chk("rst.out", OUT, 64'h0);
    chk("rst.fmt", {61'b0, imm_fmt}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases with hand-derived constants.
    step(1'b1, 32'hFFFFFFFF, "none");
    chk("none.k", OUT, 64'h0);
    step(1'b1, {12'b010000100011, 5'b10101, 3'b010, 5'b01010, 7'b0000011}, "lw");
    chk("lw.k", OUT, 64'h0000000000000423);
    chk("lw.kf", {61'b0, imm_fmt}, 64'd1);
    step(1'b1, {7'b0100001, 5'b00011, 5'b10101, 3'b010, 5'b10001, 7'b0100011}, "sw");
    chk("sw.k", OUT, 64'h0000000000000431);
    chk("sw.kf", {61'b0, imm_fmt}, 64'd2);
    step(1'b1, {7'b1100001, 5'b00011, 5'b10101, 3'b010, 5'b01110, 7'b1100011}, "beq");
    chk("beq.k", OUT, 64'hFFFFFFFFFFFFF42E);
    chk("beq.kf", {61'b0, imm_fmt}, 64'd3);
    step(1'b1, 32'h800002B7, "lui");
    chk("lui.k", OUT, 64'hFFFFFFFF80000000);
    chk("lui.kf", {61'b0, imm_fmt}, 64'd4);
    step(1'b1, 32'hFFDFF0EF, "jal");
    chk("jal.k", OUT, 64'hFFFFFFFFFFFFFFFC);
    chk("jal.kf", {61'b0, imm_fmt}, 64'd5);
    step(1'b0, 32'h12345013, "hold1");
    step(1'b0, 32'h00000000, "hold2");
    chk("hold.k", OUT, 64'hFFFFFFFFFFFFFFFC);

    // Asynchronous reset mid-stream, away from any clock edge.
    step(1'b1, 32'h7FF00013, "pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.vld", {63'b0, out_valid}, 64'h0);
    chk("arst.out", OUT, 64'h0);
    chk("arst.fmt", {61'b0, imm_fmt}, 64'h0);
    exp_out = 64'h0; exp_fmt = 3'd0; exp_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized stream: mostly known opcodes with random fields.
    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      if ($urandom_range(0, 9) < 8) w[6:0] = opc_tbl[$urandom_range(0, 11)];
      step($urandom_range(0, 4) != 0, w, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
